multiplier_top: RTL

//  Sequential unsigned multiplier with seven-segment result display; the

---
 rtl/multiplier_top_if.sv | 28 ++
 rtl/multiplier_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multiplier_top_if.sv
// Handshake and display bundle for multiplier_top.
//   start      : operation request, sampled only while the multiplier is idle
//   a, b       : unsigned operands (WIDTH bits)
//   prod_hun/ten/one : active-low seven-segment digits {g,f,e,d,c,b,a}
//   busy       : high whenever the multiplier is not idle
//   done       : one-cycle pulse when the displays update
interface multiplier_top_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [6:0]       prod_one;
  logic [6:0]       prod_ten;
  logic [6:0]       prod_hun;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  prod_one, prod_ten, prod_hun, busy, done
  );

  modport slave (
    input  start, a, b,
    output prod_one, prod_ten, prod_hun, busy, done
  );
endinterface

// File: rtl/multiplier_top.sv
// Sequential unsigned multiplier with a three-digit seven-segment display.
// Shift-add multiply over WIDTH cycles, double-dabble BCD conversion over
// 2*WIDTH cycles, then one cycle to register the decoded digits.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : multiplier_top_if slave (start/a/b in; digits, busy, done out)
module multiplier_top #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  multiplier_top_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(PW);
  localparam int unsigned BCD_W = 12;
  localparam logic [6:0]  SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {IDLE, MUL, BCD, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [6:0]         seg_one_q, seg_one_d;
  logic [6:0]         seg_ten_q, seg_ten_d;
  logic [6:0]         seg_hun_q, seg_hun_d;

  // BCD digit to active-low segments {g,f,e,d,c,b,a}; non-decimal blanks.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: add 3 to each nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    seg_one_d = seg_one_q;
    seg_ten_d = seg_ten_q;
    seg_hun_d = seg_hun_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          bcd_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        // cnt_q is the bit position of the current multiplier lsb.
        if (mplier_q[0]) begin
          acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = BCD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BCD: begin
        // The product shifts out of acc msb-first into the BCD register.
        bcd_d = {bcd_adj[BCD_W-2:0], acc_q[PW-1]};
        acc_d = acc_q << 1;
        if (cnt_q == CNT_W'(PW - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        seg_one_d = seg7(bcd_q[3:0]);
        seg_ten_d = seg7(bcd_q[7:4]);
        seg_hun_d = seg7(bcd_q[11:8]);
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_one_q <= SEG_ZERO;
      seg_ten_q <= SEG_ZERO;
      seg_hun_q <= SEG_ZERO;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      seg_one_q <= seg_one_d;
      seg_ten_q <= seg_ten_d;
      seg_hun_q <= seg_hun_d;
    end
  end

  assign bus.prod_one = seg_one_q;
  assign bus.prod_ten = seg_ten_q;
  assign bus.prod_hun = seg_hun_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
